pipeline_hazard_ctrl: RTL and testbench

- Control-side counterpart to the inter-stage pipeline buffers: generates the stall and flush inputs that the IF/ID, ID/EX and EX/MEM buffers and the PC register consume.
- Detects load-use hazards, taken branches resolved in EX, multi-cycle multiply occupancy, and MEM-stage exceptions.
- One instance per core, placed beside the datapath and driven by decode/EX/MEM status signals.

---
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush generation for load-use, branch, multiply and exception hazards.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MUL_LATENCY    = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rt,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_branch_taken,
  input  logic                      ex_mul_start,
  input  logic                      mem_exception,
  output logic                      pc_stall,
  output logic                      ifid_stall,
  output logic                      idex_stall,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic                      exmem_flush,
  output logic                      mul_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
`endif
);

  localparam int CW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  // Counter holds the number of MUL_WAIT cycles still to run, including the current one.
  localparam logic [CW-1:0] MUL_LOAD = CW'((MUL_LATENCY > 2) ? (MUL_LATENCY - 2) : 0);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          load_use;
  logic          s_pc, s_ifid, s_idex, f_ifid, f_idex, f_exmem, busy;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    s_pc    = 1'b0;
    s_ifid  = 1'b0;
    s_idex  = 1'b0;
    f_ifid  = 1'b0;
    f_idex  = 1'b0;
    f_exmem = 1'b0;
    busy    = 1'b0;
    case (state)
      RUN: begin
        if (mem_exception) begin
          f_ifid  = 1'b1;
          f_idex  = 1'b1;
          f_exmem = 1'b1;
        end else if (ex_branch_taken) begin
          f_ifid = 1'b1;
          f_idex = 1'b1;
        end else if (ex_mul_start && (MUL_LATENCY > 1)) begin
          s_pc    = 1'b1;
          s_ifid  = 1'b1;
          s_idex  = 1'b1;
          f_exmem = 1'b1;
          // A two-cycle multiply is covered entirely by this first stall cycle.
          if (MUL_LATENCY > 2) begin
            state_n = MUL_WAIT;
            cnt_n   = MUL_LOAD;
          end
        end else if (load_use) begin
          s_pc   = 1'b1;
          s_ifid = 1'b1;
          f_idex = 1'b1;
        end
      end
      MUL_WAIT: begin
        if (mem_exception) begin
          f_ifid  = 1'b1;
          f_idex  = 1'b1;
          f_exmem = 1'b1;
          cnt_n   = '0;
          state_n = RUN;
        end else begin
          s_pc    = 1'b1;
          s_ifid  = 1'b1;
          s_idex  = 1'b1;
          f_exmem = 1'b1;
          busy    = 1'b1;
          if (cnt <= CW'(1)) begin
            cnt_n   = '0;
            state_n = RUN;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = '0;
      end
    endcase
  end

  // Reset gates the outputs directly so they drop without waiting for a clock edge.
  assign pc_stall    = rst & s_pc;
  assign ifid_flush  = rst & f_ifid;
  assign idex_flush  = rst & f_idex;
  assign exmem_flush = rst & f_exmem;
  assign ifid_stall  = rst & s_ifid & ~f_ifid;
  assign idex_stall  = rst & s_idex & ~f_idex;
  assign mul_busy    = rst & busy;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pc_stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if ((ifid_flush || idex_flush || exmem_flush) && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed bench with a cycle model of the hazard controller.
module tb_pipeline_hazard_ctrl;
  localparam int RW = 5;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic          id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic          ex_branch_taken = 1'b0, ex_mul_start = 1'b0, mem_exception = 1'b0;
  logic          pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_flush, mul_busy;
  logic [6:0]    outs;

  int checks = 0;
  int errors = 0;
  int wait_left = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RW), .MUL_LATENCY(ML), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_mul_start(ex_mul_start), .mem_exception(mem_exception),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mul_busy(mul_busy)
  );

  // Output vector order: pc_stall ifid_stall idex_stall ifid_flush idex_flush exmem_flush mul_busy
  assign outs = {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_flush, mul_busy};

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic ut,
                       input logic mr, input logic [RW-1:0] rd,
                       input logic br, input logic mul, input logic exc);
    @(posedge clk);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rt = ut; ex_mem_read = mr; ex_rd = rd;
    ex_branch_taken = br; ex_mul_start = mul; mem_exception = exc;
  endtask

  task automatic idle();
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lit(input string name, input logic [6:0] exp);
    @(negedge clk);
    #1;
    check(name, outs, exp);
  endtask

  // Model: wait_left counts the extra stall cycles a multiply still owes after its first cycle.
  always @(negedge clk) begin
    logic [6:0] exp;
    int         nxt;
    logic       lu;
    lu  = ex_mem_read && (ex_rd != 0) &&
          ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    exp = 7'b0;
    nxt = wait_left;
    if (!rst) begin
      nxt = 0;
    end else if (wait_left > 0) begin
      if (mem_exception) begin
        exp = 7'b0001110;
        nxt = 0;
      end else begin
        exp = 7'b1110011;
        nxt = wait_left - 1;
      end
    end else if (mem_exception) begin
      exp = 7'b0001110;
    end else if (ex_branch_taken) begin
      exp = 7'b0001100;
    end else if (ex_mul_start) begin
      exp = 7'b1110010;
      nxt = ML - 2;
    end else if (lu) begin
      exp = 7'b1100100;
    end
    check("model", outs, exp);
    wait_left = nxt;
  end

  initial begin
    ex_branch_taken = 1'b1;
    mem_exception   = 1'b1;
    ex_mul_start    = 1'b1;
    #1;
    check("reset_forced_zero", outs, 7'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    ex_branch_taken = 1'b0; mem_exception = 1'b0; ex_mul_start = 1'b0;
    lit("after_reset", 7'b0);

    drive(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    lit("load_use_rs", 7'b1100100);
    idle();
    lit("load_use_one_cycle", 7'b0);
    drive(5'd3, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    lit("load_use_rd0_rs3", 7'b0);
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    lit("load_use_r0", 7'b0);
    drive(5'd5, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    lit("load_use_rt", 7'b1100100);
    drive(5'd5, 5'd3, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    lit("rt_not_used", 7'b0);
    drive(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
    lit("no_load", 7'b0);

    drive('0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    lit("branch", 7'b0001100);
    idle();
    lit("branch_done", 7'b0);

    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    lit("mul_c1", 7'b1110010);
    idle();
    lit("mul_c2", 7'b1110011);
    idle();
    lit("mul_c3", 7'b1110011);
    idle();
    lit("mul_c4", 7'b0);

    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    lit("mul_exc_c1", 7'b1110010);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    lit("mul_exc_c2", 7'b0001110);
    idle();
    lit("mul_exc_after", 7'b0);

    drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
    lit("exc_priority", 7'b0001110);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    lit("branch_over_mul", 7'b0001100);
    idle();
    lit("branch_over_mul_done", 7'b0);

    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    lit("wait_ign_c1", 7'b1110010);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    lit("wait_ign_branch", 7'b1110011);
    drive(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0);
    lit("wait_ign_mul_lu", 7'b1110011);
    idle();
    lit("wait_ign_done", 7'b0);

    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    lit("rst_mid_c1", 7'b1110010);
    idle();
    #2;
    check("rst_mid_busy", outs, 7'b1110011);
    rst = 1'b0;
    #1;
    check("rst_mid_async", outs, 7'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    lit("rst_mid_run", 7'b0);
    idle();
    lit("final_idle", 7'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
